instr_issue_unit: RTL and testbench
===================================

# instr_issue_unit

Instruction source and result monitor for the three-stage ALU pipeline. Holds a small loadable program, drives the pipeline's 32-bit instruction input one word per cycle, and inserts NOP bubbles for read-after-write hazards, since the pipeline has no forwarding. It also tags the pipeline's result output so each retired result is reported with its destination register.

## Interface
Parameters:
- PROG_DEPTH, 16 — program buffer entries; AW = $clog2(PROG_DEPTH).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, shared with the pipeline
- rst  in  1  synchronous active-high reset, shared with the pipeline
- prog_we  in  1  write program word (honoured only in IDLE)
- prog_addr  in  AW  program write address
- prog_data  in  32  program word
- start  in  1  begin run (honoured only in IDLE)
- run_len  in  AW+1  number of words to issue, 0..PROG_DEPTH; latched on start
- instr_out  out  32  registered; drives the pipeline instruction input
- pipe_result  in  32  pipeline result output
- res_valid  out  1  pipe_result this cycle belongs to a writing instruction
- res_rd  out  5  destination register of that result
- res_data  out  32  equals pipe_result when res_valid=1
- busy  out  1  run in progress (ISSUE or DRAIN)
- done  out  1  one-cycle pulse at end of run
- stall_cnt  out  16  bubbles inserted in current/last run; cleared on start

## Operation
- Instruction fields: OP[31:26], RD[25:21], RS1[20:16], RS2[15:11], IMM[15:0].
- OP[5]=1 means immediate form: RS2 is not read.
- OP=0 means NOP: no write, no reads; NOP word is 32'h0.
- All other OPs write RD and read RS1, plus RS2 unless in immediate form.
- Register 0 is not special.
- FSM states:
  - IDLE → ISSUE on start with run_len>0; pc=0.
  - IDLE → DONE on start with run_len=0.
  - ISSUE → DRAIN after issuing word run_len-1.
  - DRAIN → DONE after 3 cycles.
  - DONE → IDLE after 1 cycle.
- Hazard rule: a candidate word conflicts if any register it reads equals RD of a writing instruction on instr_out in either of the two preceding cycles.
  - On conflict: instr_out ← NOP, pc held, stall_cnt += 1 (saturating).
  - Otherwise: instr_out ← prog[pc], pc += 1.
- Result tag: a 3-deep shift register of {we, rd} fed from instr_out each cycle.
  - Its tail drives res_valid and res_rd.
  - res_data = pipe_result.
- Ignored inputs:
  - prog_we and start outside IDLE.
  - Writes to addresses ≥ PROG_DEPTH.
- run_len > PROG_DEPTH is clamped to PROG_DEPTH.
- Program buffer contents persist across runs; rst does not clear them.
- Outputs in IDLE/DRAIN/DONE: instr_out = NOP.

## Timing
- Word on instr_out in cycle t:
  - Its result is on pipe_result in cycle t+3.
  - It is written to the register file at the end of t+3.
  - Its RAW-dependent successor may appear no earlier than cycle t+3.
- Spacing for dependent pairs:
  - Back-to-back pair: 2 bubbles.
  - Pair at distance 2: 1 bubble.
  - Distance ≥3: none.
- start sampled in cycle s → first program word on instr_out in s+1.
- Last word on instr_out in cycle L:
  - busy=1 from s+1 through L+3.
  - done=1 in L+4 only.
- run_len=0: done=1 in s+1; busy stays 0.
- Reset (including mid-run), value in the cycle after rst:
  - state=IDLE, pc=0.
  - instr_out=0, res_valid=0, res_rd=0, busy=0, done=0, stall_cnt=0.
  - Tag shift register cleared, so no stale results are reported.
- prog_we and start in the same IDLE cycle: the write lands; the run sees the new word.

## Structure
- Shared package pipe_isa_pkg holds:
  - Field positions.
  - OP_NOP=6'h00, OP_ADD=6'h01, OP_ADDI=6'h21.
  - IMM_FLAG bit index 5.
  - PIPE_DEPTH=3.
  - NOP_WORD.
  - A reads_rs2(op) function.
- Natural sub-module: hazard_check. Combinational; takes the candidate word plus two {we, rd} history entries and returns stall.
- The top level holds the FSM, program buffer (register array, combinational read), pc, tag shift register and counters.

## Test plan
- Independent run: words ADD r1,r2,r3; ADD r4,r5,r6; ADDI r7,r8,5; run_len=3 → words on consecutive cycles, stall_cnt=0; res_valid with res_rd=1,4,7 in s+4..s+6; done at s+7.
- Back-to-back RAW: ADD r1,r2,r3 then ADD r4,r1,r5 → two NOPs between them; stall_cnt=2; second result reports res_rd=4.
- Distance-2 RAW: ADD r1..; ADD r9,r2,r3; ADD r4,r5,r1 → exactly one NOP before third word; stall_cnt=1.
- Immediate false hazard: ADD r1,r2,r3 then ADDI r4,r6 with IMM[15:11]=1 (RS2 field =1) → no stall.
- run_len=0 with start → done one cycle later, busy never 1, instr_out stays 0.
- Reset mid-ISSUE after 2 words, then a start in the same cycle as prog_we → after reset all outputs 0, start while busy ignored, new run begins at pc=0 with updated word.

Source files
------------

// File: rtl/pipe_isa_pkg.sv
// pipe_isa_pkg: instruction fields, opcodes, FSM states and hazard helpers for the issue unit.
package pipe_isa_pkg;
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RD_HI = 25;
  localparam int RD_LO = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_ADDI = 6'h21;
  localparam int IMM_FLAG = 5;
  localparam int PIPE_DEPTH = 3;
  localparam logic [31:0] NOP_WORD = 32'h0;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic       we;
    logic [4:0] rd;
  } tag_t;
  function automatic logic reads_rs2(input logic [5:0] op);
    return op != OP_NOP && !op[IMM_FLAG];
  endfunction
  function automatic logic raw_hit(input tag_t h, input logic [4:0] r);
    return h.we && h.rd == r;
  endfunction
endpackage

// File: rtl/instr_issue_unit_if.sv
// instr_issue_unit_if: program load, run control, pipeline instruction/result and status signals.
interface instr_issue_unit_if #(parameter int PROG_DEPTH = 16);
  localparam int AW = $clog2(PROG_DEPTH);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          start;
  logic [AW:0]   run_len;
  logic [31:0]   instr_out;
  logic [31:0]   pipe_result;
  logic          res_valid;
  logic [4:0]    res_rd;
  logic [31:0]   res_data;
  logic          busy;
  logic          done;
  logic [15:0]   stall_cnt;
  modport master (
    output prog_we, prog_addr, prog_data, start, run_len, pipe_result,
    input  instr_out, res_valid, res_rd, res_data, busy, done, stall_cnt
  );
  modport slave (
    input  prog_we, prog_addr, prog_data, start, run_len, pipe_result,
    output instr_out, res_valid, res_rd, res_data, busy, done, stall_cnt
  );
endinterface

// File: rtl/instr_issue_unit_hazard_check.sv
// hazard_check: flags a RAW conflict between a candidate's source registers and two in-flight writers.
module hazard_check
  import pipe_isa_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  tag_t       i_h0,
  input  tag_t       i_h1,
  output logic       o_stall
);
  logic w_r1, w_r2;
  assign w_r1 = i_op != OP_NOP;
  assign w_r2 = reads_rs2(i_op);
  assign o_stall = (w_r1 && (raw_hit(i_h0, i_rs1) || raw_hit(i_h1, i_rs1))) ||
                   (w_r2 && (raw_hit(i_h0, i_rs2) || raw_hit(i_h1, i_rs2)));
endmodule

// File: rtl/instr_issue_unit.sv
// instr_issue_unit: issues a loaded program into the no-forwarding ALU pipeline with RAW bubbles and tags results.
module instr_issue_unit
  import pipe_isa_pkg::*;
#(
  parameter int PROG_DEPTH = 16
) (
  input logic               clk,
  input logic               rst,
  instr_issue_unit_if.slave bus
);
  localparam int AW = $clog2(PROG_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(PROG_DEPTH);
  state_t      r_state, w_state_nx;
  logic [31:0] r_prog [PROG_DEPTH];
  logic [31:0] r_instr, w_cand;
  logic [AW:0] r_pc, r_len, w_pc, w_len;
  logic [1:0]  r_drain;
  logic [15:0] r_stall_cnt;
  tag_t        r_tag [PIPE_DEPTH];
  logic        w_wr, w_issue, w_stall, w_addr_ok;

  if (PROG_DEPTH == (1 << AW)) begin : g_pow2
    assign w_addr_ok = 1'b1;
  end else begin : g_npow2
    assign w_addr_ok = {1'b0, bus.prog_addr} < DEPTH;
  end

  assign w_wr = r_state == S_IDLE && bus.prog_we && w_addr_ok;
  assign w_len = bus.run_len > DEPTH ? DEPTH : bus.run_len;
  assign w_pc = r_state == S_IDLE ? '0 : r_pc;
  assign w_issue = r_state == S_ISSUE ? r_pc != r_len
                                      : (r_state == S_IDLE && bus.start && w_len != '0);
  // A word written in the start cycle must be seen by the first issue
  assign w_cand = (w_wr && bus.prog_addr == w_pc[AW-1:0]) ? bus.prog_data : r_prog[w_pc[AW-1:0]];

  hazard_check u_hazard (
    .i_op   (w_cand[OP_HI:OP_LO]),
    .i_rs1  (w_cand[RS1_HI:RS1_LO]),
    .i_rs2  (w_cand[RS2_HI:RS2_LO]),
    .i_h0   ({r_instr[OP_HI:OP_LO] != OP_NOP, r_instr[RD_HI:RD_LO]}),
    .i_h1   (r_tag[0]),
    .o_stall(w_stall)
  );

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  w_state_nx = bus.start ? (w_len == '0 ? S_DONE : S_ISSUE) : S_IDLE;
      S_ISSUE: w_state_nx = r_pc == r_len ? S_DRAIN : S_ISSUE;
      S_DRAIN: w_state_nx = r_drain == 2'd2 ? S_DONE : S_DRAIN;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc <= '0;
      r_len <= '0;
      r_instr <= NOP_WORD;
      r_drain <= '0;
      r_stall_cnt <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) r_tag[i] <= '0;
    end else begin
      r_state <= w_state_nx;
      r_drain <= r_state == S_DRAIN ? r_drain + 2'd1 : 2'd0;
      if (r_state == S_IDLE && bus.start) r_len <= w_len;
      if (w_issue) r_pc <= w_pc + (AW+1)'(!w_stall);
      r_instr <= (w_issue && !w_stall) ? w_cand : NOP_WORD;
      r_stall_cnt <= (w_issue && w_stall && r_stall_cnt != '1) ? r_stall_cnt + 16'd1
                   : (r_state == S_IDLE && bus.start) ? 16'd0 : r_stall_cnt;
      r_tag[0] <= {r_instr[OP_HI:OP_LO] != OP_NOP, r_instr[RD_HI:RD_LO]};
      for (int i = 1; i < PIPE_DEPTH; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Program storage survives rst by design
  always_ff @(posedge clk) begin
    if (w_wr) r_prog[bus.prog_addr] <= bus.prog_data;
  end

  assign bus.instr_out = r_instr;
  assign bus.res_valid = r_tag[PIPE_DEPTH-1].we;
  assign bus.res_rd = r_tag[PIPE_DEPTH-1].rd;
  assign bus.res_data = bus.pipe_result;
  assign bus.busy = r_state == S_ISSUE || r_state == S_DRAIN;
  assign bus.done = r_state == S_DONE;
  assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_instr_issue_unit.sv
// tb_instr_issue_unit: directed and randomized runs checked against a cycle-schedule reference model.
module tb_instr_issue_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] mirror [16];

  always #5 clk = ~clk;

  instr_issue_unit_if #(.PROG_DEPTH(16)) bus ();
  instr_issue_unit #(.PROG_DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'h0};
  endfunction

  function automatic logic [31:0] enci(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.prog_we = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    mirror[a] = d;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  // Issue times are derived from the timing rule: a reader may appear no
  // earlier than three cycles after its writer, words stay in order.
  task automatic run_check(input string name, input int len, input bit ws, input logic [3:0] wa,
                           input logic [31:0] wd, input bit poke);
    int n, last, total;
    int t [16];
    int ready [32];
    logic [31:0] w, exp_instr, pr;
    logic exp_v, exp_busy, exp_done;
    logic [4:0] exp_rd;
    if (ws) mirror[wa] = wd;
    n = len > 16 ? 16 : len;
    last = 0;
    for (int r = 0; r < 32; r++) ready[r] = 0;
    for (int i = 0; i < n; i++) begin
      int ti;
      w = mirror[i];
      ti = (i == 0) ? 1 : t[i-1] + 1;
      if (w[31:26] != 6'h0) begin
        if (ready[w[20:16]] > ti) ti = ready[w[20:16]];
        if (!w[31] && ready[w[15:11]] > ti) ti = ready[w[15:11]];
        ready[w[25:21]] = ti + 3;
      end
      t[i] = ti;
      last = ti;
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.run_len = 5'(len);
    if (ws) begin
      bus.prog_we = 1'b1;
      bus.prog_addr = wa;
      bus.prog_data = wd;
    end
    @(negedge clk);
    total = n == 0 ? 3 : last + 5;
    for (int c = 1; c <= total; c++) begin
      bus.start = 1'b0;
      bus.prog_we = 1'b0;
      if (poke && c == 2) begin
        bus.start = 1'b1;
        bus.run_len = 5'd1;
        bus.prog_we = 1'b1;
        bus.prog_addr = 4'd0;
        bus.prog_data = $urandom;
      end
      pr = $urandom;
      bus.pipe_result = pr;
      #1;
      exp_instr = 32'h0;
      exp_v = 1'b0;
      exp_rd = 5'd0;
      for (int i = 0; i < n; i++) begin
        if (t[i] == c) exp_instr = mirror[i];
        if (t[i] == c - 3 && mirror[i][31:26] != 6'h0) begin
          exp_v = 1'b1;
          exp_rd = mirror[i][25:21];
        end
      end
      exp_busy = n != 0 && c <= last + 3;
      exp_done = n == 0 ? c == 1 : c == last + 4;
      checks += 4;
      if (bus.instr_out !== exp_instr) begin
        errors++;
        $display("FAIL %s c%0d instr_out got %h want %h", name, c, bus.instr_out, exp_instr);
      end
      if (bus.res_valid !== exp_v) begin
        errors++;
        $display("FAIL %s c%0d res_valid got %b want %b", name, c, bus.res_valid, exp_v);
      end
      if (bus.busy !== exp_busy) begin
        errors++;
        $display("FAIL %s c%0d busy got %b want %b", name, c, bus.busy, exp_busy);
      end
      if (bus.done !== exp_done) begin
        errors++;
        $display("FAIL %s c%0d done got %b want %b", name, c, bus.done, exp_done);
      end
      if (exp_v) begin
        checks += 2;
        if (bus.res_rd !== exp_rd) begin
          errors++;
          $display("FAIL %s c%0d res_rd got %0d want %0d", name, c, bus.res_rd, exp_rd);
        end
        if (bus.res_data !== pr) begin
          errors++;
          $display("FAIL %s c%0d res_data got %h want %h", name, c, bus.res_data, pr);
        end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.prog_we = 1'b0;
    checks++;
    if (bus.stall_cnt !== 16'(n == 0 ? 0 : last - n)) begin
      errors++;
      $display("FAIL %s stall_cnt got %0d want %0d", name, bus.stall_cnt, n == 0 ? 0 : last - n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.instr_out, bus.res_valid, bus.res_rd, bus.busy, bus.done, bus.stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset outputs got instr=%h v=%b rd=%0d busy=%b done=%b stall=%0d want all 0",
               bus.instr_out, bus.res_valid, bus.res_rd, bus.busy, bus.done, bus.stall_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_independent();
    wr(4'd0, enc(6'h01, 5'd1, 5'd2, 5'd3));
    wr(4'd1, enc(6'h01, 5'd4, 5'd5, 5'd6));
    wr(4'd2, enci(6'h21, 5'd7, 5'd8, 16'd5));
    run_check("independent", 3, 1'b0, 4'd0, 32'h0, 1'b0);
    checks++;
    if (bus.stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL independent stall got %0d want 0", bus.stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    wr(4'd0, enc(6'h01, 5'd1, 5'd2, 5'd3));
    wr(4'd1, enc(6'h01, 5'd4, 5'd1, 5'd5));
    run_check("back_to_back", 2, 1'b0, 4'd0, 32'h0, 1'b0);
    checks++;
    if (bus.stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL back_to_back stall got %0d want 2", bus.stall_cnt);
    end
  endtask

  task automatic test_distance2();
    wr(4'd0, enc(6'h01, 5'd1, 5'd2, 5'd3));
    wr(4'd1, enc(6'h01, 5'd9, 5'd2, 5'd3));
    wr(4'd2, enc(6'h01, 5'd4, 5'd5, 5'd1));
    run_check("distance2", 3, 1'b0, 4'd0, 32'h0, 1'b0);
    checks++;
    if (bus.stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL distance2 stall got %0d want 1", bus.stall_cnt);
    end
  endtask

  task automatic test_imm_false();
    wr(4'd0, enc(6'h01, 5'd1, 5'd2, 5'd3));
    wr(4'd1, enci(6'h21, 5'd4, 5'd6, 16'h0800));
    run_check("imm_false", 2, 1'b0, 4'd0, 32'h0, 1'b0);
    checks++;
    if (bus.stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL imm_false stall got %0d want 0", bus.stall_cnt);
    end
  endtask

  task automatic test_zero_len();
    run_check("zero_len", 0, 1'b0, 4'd0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_midrun();
    wr(4'd0, enc(6'h01, 5'd1, 5'd2, 5'd3));
    wr(4'd1, enc(6'h01, 5'd4, 5'd5, 5'd6));
    wr(4'd2, enc(6'h01, 5'd7, 5'd1, 5'd4));
    @(negedge clk);
    bus.start = 1'b1;
    bus.run_len = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.instr_out, bus.res_valid, bus.res_rd, bus.busy, bus.done, bus.stall_cnt} !== '0) begin
      errors++;
      $display("FAIL midrun_reset outputs got instr=%h v=%b rd=%0d busy=%b done=%b stall=%0d want all 0",
               bus.instr_out, bus.res_valid, bus.res_rd, bus.busy, bus.done, bus.stall_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL midrun_stale k%0d valid=%b busy=%b want 0 0", k, bus.res_valid, bus.busy);
      end
    end
    run_check("after_reset", 3, 1'b1, 4'd0, enc(6'h01, 5'd10, 5'd11, 5'd12), 1'b1);
    run_check("poke_ignored", 1, 1'b0, 4'd0, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      for (int a = 0; a < 16; a++) begin
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 3);
        w[31:26] = k == 0 ? 6'h00 : k == 1 ? 6'h01 : k == 2 ? 6'h21 : 6'($urandom);
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        w[15:11] = 5'($urandom_range(0, 3));
        if (k == 0 && r[0]) w = 32'h0;
        wr(4'(a), w);
      end
      run_check("random", $urandom_range(0, 20), 1'($urandom), 4'($urandom), 32'($urandom), 1'b0);
    end
  endtask

  initial begin
    bus.prog_we = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.start = 1'b0;
    bus.run_len = '0;
    bus.pipe_result = '0;
    test_reset();
    test_independent();
    test_back_to_back();
    test_distance2();
    test_imm_false();
    test_zero_len();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
